// File: rtl/lsu_pkg.sv
// Shared LSU definitions: op codes, response error codes, FSM state encoding.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a. LSU_MISALIGNED_SPLIT_EN adds the second-beat states.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_SB  = 3'd3,
    OP_LBU = 3'd4,
    OP_LHU = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    ERR_OK         = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_ACCESS     = 2'd2
  } lsu_err_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

`ifdef LSU_MISALIGNED_SPLIT_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_REQ2  = 3'd4,
    S_WAIT2 = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;
`endif

  function automatic logic op_is_store(lsu_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_unsigned(lsu_op_t op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic [1:0] op_size(lsu_op_t op);
    logic [1:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_B;
      OP_LH, OP_LHU, OP_SH: sz = SZ_H;
      default:              sz = SZ_W;
    endcase
    return sz;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] a);
    logic m;
    case (op_size(op))
      SZ_H:    m = a[0];
      SZ_W:    m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response and memory-side bus signals of the LSU controller.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates requests; memory stalls via mem_gnt / mem_rvalid.
interface lsu_mem_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [2:0]          req_op;
  logic [ADDR_W-1:0]   req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic                rsp_valid;
  logic [XLEN-1:0]     rsp_rdata;
  logic [1:0]          rsp_err;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [XLEN/8-1:0]   mem_be;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [XLEN-1:0]     mem_rdata;

  // Controller view.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // Core + memory environment view.
  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables, store data shift, load shift and sign/zero extend.
// Latency: combinational, zero cycles.
// Backpressure: none. Outputs are double width so a split access can use the upper beat.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsu_op_t                   op,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [XLEN-1:0]           wdata,
  input  logic [2*XLEN-1:0]         rdata2,
  output logic [2*XLEN/8-1:0]       be2,
  output logic [2*XLEN-1:0]         wdata2,
  output logic [XLEN-1:0]           rdata_ext
);
  localparam int NB = XLEN / 8;

  logic [2*NB-1:0] mask;
  logic [XLEN-1:0] sh;
  logic            fill;
  int              w;

  // Lane mask and store data shifted up to the byte offset.
  always_comb begin
    mask = '0;
    case (op_size(op))
      SZ_B:    mask[0]   = 1'b1;
      SZ_H:    mask[1:0] = 2'b11;
      default: mask[3:0] = 4'hf;
    endcase
    be2    = mask << off;
    wdata2 = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  end

  // Load data shifted down to bit 0, then extended above the access width.
  always_comb begin
    sh = XLEN'(rdata2 >> {off, 3'b000});
    case (op_size(op))
      SZ_B:    w = 8;
      SZ_H:    w = 16;
      default: w = 32;
    endcase
    fill = !op_is_unsigned(op) && sh[w-1];
    rdata_ext = '0;
    for (int i = 0; i < XLEN; i++) begin
      rdata_ext[i] = (i < w) ? sh[i] : fill;
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU memory controller: one core request becomes one (or two, LSU_MISALIGNED_SPLIT_EN) bus beats.
// Latency: capture at T, mem_req at T+1, best-case rsp_valid at T+3; misaligned error at T+1.
// Backpressure: req_ready only in IDLE; each beat waits on mem_gnt/mem_rvalid up to TIMEOUT cycles.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_ctrl_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  lsu_err_t          err_q;
  logic [CW-1:0]     cnt_q;

  logic              rsp_set;
  lsu_err_t          rsp_err_d;
  logic [XLEN-1:0]   rsp_dat_d;
  logic              beat1_cap;
  logic              tmo;
  logic [ADDR_W-1:0] base;

  logic [2*XLEN-1:0] rdata2;
  logic [2*NB-1:0]   be2;
  logic [2*XLEN-1:0] wdata2;
  logic [XLEN-1:0]   rdata_ext;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              mis_q;
  logic [XLEN-1:0]   rdata1_q;
  // Second beat of a split load carries the upper bytes.
  assign rdata2 = (state_q == S_WAIT2) ? {bus.mem_rdata, rdata1_q} : {{XLEN{1'b0}}, bus.mem_rdata};
`else
  logic unused_hi;
  assign rdata2    = {{XLEN{1'b0}}, bus.mem_rdata};
  assign unused_hi = ^{be2[2*NB-1:NB], wdata2[2*XLEN-1:XLEN]};
`endif

  assign tmo  = (cnt_q >= CW'(TIMEOUT - 1));
  assign base = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .op        (op_q),
    .off       (addr_q[OFFW-1:0]),
    .wdata     (wdata_q),
    .rdata2    (rdata2),
    .be2       (be2),
    .wdata2    (wdata2),
    .rdata_ext (rdata_ext)
  );

  // State register; reset aborts any transaction without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the response to latch when DONE is entered.
  always_comb begin
    state_d   = state_q;
    rsp_set   = 1'b0;
    rsp_err_d = ERR_OK;
    rsp_dat_d = '0;
    beat1_cap = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          state_d = S_REQ;
`else
          if (is_misaligned(lsu_op_t'(bus.req_op), bus.req_addr[1:0])) begin
            state_d   = S_DONE;
            rsp_set   = 1'b1;
            rsp_err_d = ERR_MISALIGNED;
          end else begin
            state_d = S_REQ;
          end
`endif
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          state_d = S_WAIT;
        end else if (tmo) begin
          state_d   = S_DONE;
          rsp_set   = 1'b1;
          rsp_err_d = ERR_ACCESS;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (mis_q) begin
            state_d   = S_REQ2;
            beat1_cap = 1'b1;
          end else
`endif
          begin
            state_d   = S_DONE;
            rsp_set   = 1'b1;
            rsp_dat_d = op_is_store(op_q) ? '0 : rdata_ext;
          end
        end else if (tmo) begin
          state_d   = S_DONE;
          rsp_set   = 1'b1;
          rsp_err_d = ERR_ACCESS;
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_REQ2: begin
        if (bus.mem_gnt) begin
          state_d = S_WAIT2;
        end else if (tmo) begin
          state_d   = S_DONE;
          rsp_set   = 1'b1;
          rsp_err_d = ERR_ACCESS;
        end
      end
      S_WAIT2: begin
        if (bus.mem_rvalid) begin
          state_d   = S_DONE;
          rsp_set   = 1'b1;
          rsp_dat_d = op_is_store(op_q) ? '0 : rdata_ext;
        end else if (tmo) begin
          state_d   = S_DONE;
          rsp_set   = 1'b1;
          rsp_err_d = ERR_ACCESS;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and response/beat data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_LB;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
`ifdef LSU_MISALIGNED_SPLIT_EN
      mis_q    <= 1'b0;
      rdata1_q <= '0;
`endif
    end else begin
      if (state_q == S_IDLE && bus.req_valid) begin
        op_q    <= lsu_op_t'(bus.req_op);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
        mis_q   <= is_misaligned(lsu_op_t'(bus.req_op), bus.req_addr[1:0]);
`endif
      end
      if (rsp_set) begin
        rdata_q <= rsp_dat_d;
        err_q   <= rsp_err_d;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (beat1_cap) rdata1_q <= bus.mem_rdata;
`endif
    end
  end

  // Per-beat cycle counter: zero at the start of each beat, counts while the beat is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE || state_q == S_DONE || beat1_cap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Bus outputs are driven only while a beat is being requested; zero otherwise.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_DONE);
    bus.rsp_rdata = (state_q == S_DONE) ? rdata_q : '0;
    bus.rsp_err   = (state_q == S_DONE) ? err_q : ERR_OK;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    if (state_q == S_REQ) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = op_is_store(op_q);
      bus.mem_addr  = base;
      bus.mem_be    = be2[NB-1:0];
      bus.mem_wdata = op_is_store(op_q) ? wdata2[XLEN-1:0] : '0;
    end
`ifdef LSU_MISALIGNED_SPLIT_EN
    if (state_q == S_REQ2) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = op_is_store(op_q);
      bus.mem_addr  = base + ADDR_W'(NB);
      bus.mem_be    = be2[2*NB-1:NB];
      bus.mem_wdata = op_is_store(op_q) ? wdata2[2*XLEN-1:XLEN] : '0;
    end
`endif
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: aligned loads/stores, misalignment, timeout, reset abort.
// Latency: checks the T+1 / T+3 response timing cycle by cycle.
// Backpressure: memory grant/valid are driven directly by the stimulus.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  lsu_mem_ctrl_if #(.XLEN(32), .ADDR_W(32)) bus ();

  lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] ewdata;
    logic [31:0] erdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Aligned access with immediate grant and data on the following cycle.
  task automatic txn(input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    chk({v.tag, ".ready"}, bus.req_ready, 1);
    cyc();
    bus.req_valid = 1'b0;
    chk({v.tag, ".req"},   bus.mem_req, 1);
    chk({v.tag, ".addr"},  bus.mem_addr, {v.addr[31:2], 2'b00});
    chk({v.tag, ".be"},    bus.mem_be, v.be);
    chk({v.tag, ".we"},    bus.mem_we, v.we);
    chk({v.tag, ".wdata"}, bus.mem_wdata, v.ewdata);
    chk({v.tag, ".rv1"},   bus.rsp_valid, 0);
    bus.mem_gnt = 1'b1;
    cyc();
    bus.mem_gnt = 1'b0;
    chk({v.tag, ".reqoff"}, bus.mem_req, 0);
    chk({v.tag, ".rv2"},    bus.rsp_valid, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = v.rdata;
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    chk({v.tag, ".rv3"},   bus.rsp_valid, 1);
    chk({v.tag, ".rdata"}, bus.rsp_rdata, v.erdata);
    chk({v.tag, ".err"},   bus.rsp_err, 0);
    cyc();
    chk({v.tag, ".rvoff"}, bus.rsp_valid, 0);
  endtask

  task automatic mis(input string tag, input logic [2:0] op, input logic [31:0] addr);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = 32'hcafef00d;
    cyc();
    bus.req_valid = 1'b0;
    chk({tag, ".rv"},    bus.rsp_valid, 1);
    chk({tag, ".err"},   bus.rsp_err, 1);
    chk({tag, ".rdata"}, bus.rsp_rdata, 0);
    chk({tag, ".noreq"}, bus.mem_req, 0);
    cyc();
    chk({tag, ".rvoff"}, bus.rsp_valid, 0);
    chk({tag, ".noreq2"}, bus.mem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{"sw104",  OP_SW,  32'h104, 32'hdeadbeef, 32'hffffffff, 4'hf, 1'b1, 32'hdeadbeef, 32'h0};
    vecs[1] = '{"lb203",  OP_LB,  32'h203, 32'h0,        32'h80ffffff, 4'h8, 1'b0, 32'h0,        32'hffffff80};
    vecs[2] = '{"lbu203", OP_LBU, 32'h203, 32'h0,        32'h80ffffff, 4'h8, 1'b0, 32'h0,        32'h00000080};
    vecs[3] = '{"sh102",  OP_SH,  32'h102, 32'h00001234, 32'h0,        4'hc, 1'b1, 32'h12340000, 32'h0};
    vecs[4] = '{"lh102",  OP_LH,  32'h102, 32'h0,        32'h80010000, 4'hc, 1'b0, 32'h0,        32'hffff8001};
    vecs[5] = '{"lhu102", OP_LHU, 32'h102, 32'h0,        32'h80010000, 4'hc, 1'b0, 32'h0,        32'h00008001};
    vecs[6] = '{"lw100",  OP_LW,  32'h100, 32'h0,        32'h12345678, 4'hf, 1'b0, 32'h0,        32'h12345678};
    vecs[7] = '{"sb101",  OP_SB,  32'h101, 32'h000000ab, 32'h0,        4'h2, 1'b1, 32'h0000ab00, 32'h0};
    vecs[8] = '{"lb200",  OP_LB,  32'h200, 32'h0,        32'hffffff7f, 4'h1, 1'b0, 32'h0,        32'h0000007f};
    vecs[9] = '{"lh200",  OP_LH,  32'h200, 32'h0,        32'hffff7fff, 4'h3, 1'b0, 32'h0,        32'h00007fff};

    bus.req_valid  = 1'b1;
    bus.req_op     = OP_SW;
    bus.req_addr   = 32'h104;
    bus.req_wdata  = 32'h11111111;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hffffffff;
    cyc();
    cyc();
    // Outputs while reset is held, with active-looking inputs.
    chk("rst.ready", bus.req_ready, 1);
    chk("rst.req",   bus.mem_req, 0);
    chk("rst.we",    bus.mem_we, 0);
    chk("rst.be",    bus.mem_be, 0);
    chk("rst.addr",  bus.mem_addr, 0);
    chk("rst.wdata", bus.mem_wdata, 0);
    chk("rst.rv",    bus.rsp_valid, 0);
    chk("rst.rdata", bus.rsp_rdata, 0);
    chk("rst.err",   bus.rsp_err, 0);
    bus.req_valid  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    rst = 1'b0;
    cyc();
    chk("post.ready", bus.req_ready, 1);
    chk("post.req",   bus.mem_req, 0);

    foreach (vecs[i]) txn(vecs[i]);

`ifdef LSU_MISALIGNED_SPLIT_EN
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h101;
    cyc();
    bus.req_valid = 1'b0;
    chk("split.b1req",  bus.mem_req, 1);
    chk("split.b1be",   bus.mem_be, 4'he);
    chk("split.b1addr", bus.mem_addr, 32'h100);
    bus.mem_gnt = 1'b1;
    cyc();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h44332211;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("split.b1rv",   bus.rsp_valid, 0);
    chk("split.b2req",  bus.mem_req, 1);
    chk("split.b2be",   bus.mem_be, 4'h1);
    chk("split.b2addr", bus.mem_addr, 32'h104);
    bus.mem_gnt = 1'b1;
    cyc();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h88776655;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("split.rv",    bus.rsp_valid, 1);
    chk("split.rdata", bus.rsp_rdata, 32'h55443322);
    chk("split.err",   bus.rsp_err, 0);
    cyc();
`else
    mis("mis.lw101", OP_LW, 32'h101);
    mis("mis.lh103", OP_LH, 32'h103);
    mis("mis.sw102", OP_SW, 32'h102);
`endif

    // Grant never comes; a stray rvalid during REQ must be ignored.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h300;
    cyc();
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5a5a5a5a;
    n = 0;
    for (int i = 0; i < 3 * TMO && !bus.rsp_valid; i++) begin
      if (bus.mem_req) n++;
      cyc();
    end
    bus.mem_rvalid = 1'b0;
    chk("tmo.cycles", n, TMO);
    chk("tmo.rv",     bus.rsp_valid, 1);
    chk("tmo.err",    bus.rsp_err, 2);
    chk("tmo.rdata",  bus.rsp_rdata, 0);
    chk("tmo.noreq",  bus.mem_req, 0);
    cyc();
    chk("tmo.ready",  bus.req_ready, 1);

    // Reset pulse while waiting for load data.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h400;
    cyc();
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b1;
    cyc();
    bus.mem_gnt = 1'b0;
    chk("rstw.inwait", bus.req_ready, 0);
    rst = 1'b1;
    #1;
    chk("rstw.ready", bus.req_ready, 1);
    chk("rstw.rv",    bus.rsp_valid, 0);
    cyc();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h77777777;
    chk("rstw.idle",  bus.req_ready, 1);
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("rstw.norsp1", bus.rsp_valid, 0);
    chk("rstw.noreq",  bus.mem_req, 0);
    cyc();
    chk("rstw.norsp2", bus.rsp_valid, 0);

    txn(vecs[6]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
